// File: rtl/fpu_pkg.sv
// fpu_pkg: shared constants for the FPU issue stage.
//   Opcodes and funct5 codes of the float instructions the issue stage
//   classifies, plus default bubble encoding and writeback latency.
package fpu_pkg;
    localparam logic [6:0] OPC_OPFP  = 7'b1010011;
    localparam logic [6:0] OPC_FLW   = 7'b0000111;
    localparam logic [6:0] OPC_FSW   = 7'b0100111;
    localparam logic [4:0] F5_ADD    = 5'b00000;
    localparam logic [4:0] F5_SUB    = 5'b00001;
    localparam logic [4:0] F5_MUL    = 5'b00010;
    localparam logic [4:0] F5_CVT_SW = 5'b11010;
    localparam logic [4:0] F5_CVT_WS = 5'b11000;
    localparam logic [31:0] NOP_INST_DEF = 32'h00000013;
    localparam int WB_LAT_DEF = 5;
endpackage

// File: rtl/fpu_issue_if.sv
// fpu_issue_if: upstream handshake and FPU instruction bus of the issue stage.
//   slave  (issue stage): in_valid/in_inst/flush in; in_ready, fpu_inst,
//                         fpu_issue, raw_stall out.
//   master (environment): the mirror image.
interface fpu_issue_if;
    logic        in_valid;
    logic [31:0] in_inst;
    logic        in_ready;
    logic        flush;
    logic [31:0] fpu_inst;
    logic        fpu_issue;
    logic        raw_stall;
    modport slave (
        input  in_valid, in_inst, flush,
        output in_ready, fpu_inst, fpu_issue, raw_stall
    );
    modport master (
        output in_valid, in_inst, flush,
        input  in_ready, fpu_inst, fpu_issue, raw_stall
    );
endinterface

// File: rtl/fpu_rw_decode.sv
// fpu_rw_decode: combinational float-register read/write classification.
//   in:  inst   - 32-bit RISC-V instruction
//   out: wr_rd  - writes float rd;  rd_rs1/rd_rs2 - read float rs1/rs2
//        rd, rs1, rs2 - register fields
module fpu_rw_decode
    import fpu_pkg::*;
(
    input  logic [31:0] inst,
    output logic        wr_rd,
    output logic        rd_rs1,
    output logic        rd_rs2,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2
);
    logic [6:0] opc;
    logic [4:0] f5;
    logic       opfp;
    logic       arith;
    logic       unused;

    assign opc    = inst[6:0];
    assign f5     = inst[31:27];
    assign rd     = inst[11:7];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign unused = ^{inst[26:25], inst[14:12]};
    assign opfp   = opc == OPC_OPFP;
    assign arith  = opfp && (f5 == F5_ADD || f5 == F5_SUB || f5 == F5_MUL);
    assign wr_rd  = opc == OPC_FLW || arith || (opfp && f5 == F5_CVT_SW);
    assign rd_rs1 = arith || (opfp && f5 == F5_CVT_WS);
    assign rd_rs2 = arith || opc == OPC_FSW;
endmodule

// File: rtl/fpu_issue.sv
// fpu_issue: RAW-hazard issue stage in front of a fixed-latency, non-forwarding FPU.
//   clk, rstn (async active-low); bus: fpu_issue_if.slave
//   A per-register countdown marks pending float writes; readers stall
//   while the count exceeds TH. Output is registered: one instruction or
//   NOP bubble per cycle.
//   Macro FPU_REGFILE_WT_EN: write-through regfile, readers may go one cycle earlier.
module fpu_issue
    import fpu_pkg::*;
#(
    parameter int          WB_LAT   = WB_LAT_DEF,
    parameter int          CNT_W    = 3,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input logic        clk,
    input logic        rstn,
    fpu_issue_if.slave bus
);
`ifdef FPU_REGFILE_WT_EN
    localparam logic [CNT_W-1:0] TH = CNT_W'(1);
`else
    localparam logic [CNT_W-1:0] TH = '0;
`endif

    logic             wr_rd, rd_rs1, rd_rs2;
    logic [4:0]       rd, rs1, rs2;
    logic [CNT_W-1:0] cnt [32];
    logic             raw;
    logic             accept;

    fpu_rw_decode u_dec (
        .inst   (bus.in_inst),
        .wr_rd  (wr_rd),
        .rd_rs1 (rd_rs1),
        .rd_rs2 (rd_rs2),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2)
    );

    // Only writes already in flight count; the instruction's own rd reload
    // lands after this check, so rd == rs1 does not self-block.
    assign raw           = (rd_rs1 && cnt[rs1] > TH) || (rd_rs2 && cnt[rs2] > TH);
    assign bus.in_ready  = ~raw & ~bus.flush;
    assign bus.raw_stall = bus.in_valid & raw;
    assign accept        = bus.in_valid & bus.in_ready;

    // Counters keep draining through flushes: issued writes still complete.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 32; i++)
                cnt[i] <= (accept && wr_rd && rd == 5'(i)) ? CNT_W'(WB_LAT)
                                                            : cnt[i] - CNT_W'(cnt[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.fpu_inst  <= NOP_INST;
            bus.fpu_issue <= 1'b0;
        end else begin
            bus.fpu_inst  <= accept ? bus.in_inst : NOP_INST;
            bus.fpu_issue <= accept;
        end
    end
endmodule

// File: tb/tb_fpu_issue.sv
// tb_fpu_issue: directed self-checking bench for fpu_issue.
module tb_fpu_issue;
`ifdef FPU_REGFILE_WT_EN
    localparam int ACC = 5;
`else
    localparam int ACC = 6;
`endif
    localparam logic [31:0] NOP     = 32'h00000013;
    localparam logic [31:0] ADD_F1  = 32'h003100D3; // fadd.s f1,f2,f3
    localparam logic [31:0] ADD_F4  = 32'h00508253; // fadd.s f4,f1,f5
    localparam logic [31:0] MUL_F6  = 32'h10838353; // fmul.s f6,f7,f8
    localparam logic [31:0] FLW_F9  = 32'h00052487; // flw f9,0(x10)
    localparam logic [31:0] FLW_F1  = 32'h00052087; // flw f1,0(x10)
    localparam logic [31:0] FSW_F1  = 32'h00152027; // fsw f1,0(x10)
    localparam logic [31:0] CVT_F2  = 32'hD0028153; // fcvt.s.w f2,x5
    localparam logic [31:0] MUL_F1  = 32'h103100D3; // fmul.s f1,f2,f3

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    fpu_issue_if bus();
    fpu_issue dut (.clk(clk), .rstn(rstn), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Offer inst until accepted; stall cycles must equal exp_stall.
    task automatic issue(input string tag, input logic [31:0] inst, input int exp_stall);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        #1;
        while (!bus.in_ready && n < 20) begin
            chk({tag, "_raw"}, 32'(bus.raw_stall), 32'd1);
            tick();
            chk({tag, "_bubble"}, bus.fpu_inst, NOP);
            n++;
        end
        chk({tag, "_stalls"}, 32'(n), 32'(exp_stall));
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_issue"}, 32'(bus.fpu_issue), 32'd1);
        chk({tag, "_inst"}, bus.fpu_inst, inst);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_inst  = NOP;
        bus.flush    = 1'b0;
        tick();
        tick();
        chk("rst_inst", bus.fpu_inst, NOP);
        chk("rst_issue", 32'(bus.fpu_issue), 32'd0);
        rstn = 1'b1;
        #1;
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        tick();

        // RAW pair
        issue("raw_w", ADD_F1, 0);
        issue("raw_r", ADD_F4, ACC - 1);
        idle(8);

        // independent back-to-back stream
        issue("ind_add", ADD_F1, 0);
        issue("ind_mul", MUL_F6, 0);
        issue("ind_flw", FLW_F9, 0);
        idle(8);

        // FSW reading f1 right after flw f1
        issue("fsw_w", FLW_F1, 0);
        issue("fsw_r", FSW_F1, ACC - 1);
        idle(8);

        // fcvt.s.w reads no float register
        issue("cvt_w", ADD_F1, 0);
        issue("cvt", CVT_F2, 0);
        idle(8);

        // WAW reload pushes the reader out
        issue("waw_1", ADD_F1, 0);
        idle(2);
        issue("waw_2", MUL_F1, 0);
        issue("waw_r", ADD_F4, ACC - 1);
        idle(8);

        // flush blocks an otherwise hazard-free instruction, counters keep running
        issue("fl_w", ADD_F1, 0);
        bus.in_valid = 1'b1;
        bus.in_inst  = MUL_F6;
        bus.flush    = 1'b1;
        #1;
        chk("fl_ready", 32'(bus.in_ready), 32'd0);
        chk("fl_raw", 32'(bus.raw_stall), 32'd0);
        tick();
        chk("fl_inst", bus.fpu_inst, NOP);
        chk("fl_issue", 32'(bus.fpu_issue), 32'd0);
        bus.flush = 1'b0;
        issue("fl_r", ADD_F4, ACC - 2);
        idle(8);

        // async reset mid-stall
        issue("ar_w", ADD_F1, 0);
        bus.in_valid = 1'b1;
        bus.in_inst  = ADD_F4;
        #1;
        chk("ar_raw_before", 32'(bus.raw_stall), 32'd1);
        rstn = 1'b0;
        #1;
        chk("ar_raw_after", 32'(bus.raw_stall), 32'd0);
        chk("ar_inst", bus.fpu_inst, NOP);
        chk("ar_issue", 32'(bus.fpu_issue), 32'd0);
        bus.in_valid = 1'b0;
        tick();
        rstn = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fpu_issue.md
Name: fpu_issue

Overview:
- Issue/hazard stage directly upstream of the FPU pipeline.
- Accepts decoded FP instructions over a valid/ready handshake and drives the FPU instruction bus through a registered output, one instruction or NOP bubble per cycle.
- The FPU has no forwarding and a fixed-latency float-register writeback. This block keeps a per-register scoreboard and stalls any instruction that would read a float register before its pending write is visible.

Parameters:
- WB_LAT, 5: cycles from the FPU sampling an instruction to its float-register write edge.
- CNT_W, 3: scoreboard counter width; must satisfy 2^CNT_W > WB_LAT.
- NOP_INST, 32'h00000013: bubble encoding (addi x0,x0,0); the FPU treats it as no-write.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream offers in_inst.
- in_inst  in  32  RISC-V instruction (OP-FP 1010011, FLW 0000111, FSW 0100111; anything else is no-op).
- in_ready  out  1  combinational: instruction accepted this cycle if in_valid.
- flush  in  1  discard the offered instruction this cycle.
- fpu_inst  out  32  registered instruction to the FPU.
- fpu_issue  out  1  registered; 1 when fpu_inst is a real accepted instruction.
- raw_stall  out  1  combinational: in_valid and a RAW hazard is blocking.

Behaviour:
- Reset (async, rstn=0):
  - All scoreboard counters = 0.
  - fpu_inst = NOP_INST, fpu_issue = 0.
  - in_ready = 1 once rstn deasserts, unless flush is asserted.
- Classification, per in_inst:
  - Writes freg rd: FLW; OP-FP with funct5 00000 (fadd), 00001 (fsub), 00010 (fmul), 11010 (fcvt.s.w).
  - Reads freg rs1: OP-FP fadd/fsub/fmul/fcvt.w.s (11000).
  - Reads freg rs2: fadd/fsub/fmul; FSW.
  - fcvt.s.w and FLW read no freg. f0 is an ordinary register, not hardwired.
- Hazard: raw = (reads_rs1 and cnt[rs1] > TH) or (reads_rs2 and cnt[rs2] > TH), with TH = 0.
- Handshake:
  - in_ready = ~raw & ~flush.
  - accept = in_valid & in_ready.
- Output register, every edge:
  - fpu_inst <= accept ? in_inst : NOP_INST.
  - fpu_issue <= accept.
  - Latency from accept to FPU input is one cycle.
- Scoreboard, every edge:
  - Each nonzero counter decrements by 1.
  - If accept and the instruction writes rd, cnt[rd] <= WB_LAT. This reload overrides the decrement of the same entry.
- Timing: a writer accepted in cycle t unblocks readers of its rd at cycle t+6. The reader reaches the FPU at t+7, one cycle after the t+6 write edge.
- WAW needs no stall: all writes share one latency and complete in order. A reload of a busy entry is legal.
- Self-dependence (rd == rs1 on the same instruction): only older pending writes count; the instruction's own rd reload happens after the check.
- Flush:
  - Blocks acceptance that cycle; fpu_inst becomes NOP.
  - Counters keep running, because instructions already issued still complete.
- Upstream must hold in_inst stable while in_valid=1 and in_ready=0.
- Reset mid-operation clears all counters immediately. In-flight FPU results are the system's concern.

Optional Feature:
- Macro: FPU_REGFILE_WT_EN.
- Defined: the float register file writes through, so TH = 1. A dependent may be accepted at t+5.
- Undefined: TH = 0 as above.

Decomposition:
- Package fpu_pkg holds:
  - Opcode constants: OPC_OPFP, OPC_FLW, OPC_FSW.
  - funct5 constants: F5_ADD, F5_SUB, F5_MUL, F5_CVT_SW, F5_CVT_WS.
  - NOP_INST default and WB_LAT default.
- One natural sub-module: fpu_rw_decode, combinational. Input: in_inst. Outputs: wr_rd, rd_rs1, rd_rs2, rd, rs1, rs2.

Test Plan:
- After reset: fpu_inst=32'h00000013, fpu_issue=0, in_ready=1. Asserting rstn=0 mid-stall clears raw_stall within the same cycle.
- RAW pair: fadd.s f1,f2,f3 (32'h003100D3) accepted at cycle 0, fadd.s f4,f1,f5 (32'h00508253) held valid.
  - Required: raw_stall=1 in cycles 1-5, accept at cycle 6.
  - fpu_inst sequence: ADD, then 5 NOPs, then second ADD.
  - With FPU_REGFILE_WT_EN: accept at cycle 5.
- Independent stream: fadd f1, fmul f6,f7,f8, flw f9 on back-to-back cycles. Required: no stall, fpu_issue=1 three consecutive cycles.
- FSW reading rs2 = f1, right after flw f1. Required: stall 5 cycles. fcvt.s.w f2 (reads x-reg only) behind any writer issues without stall.
- WAW reload: fadd f1 at cycle 0, fmul f1 at cycle 3, then a reader of f1. Required: reader accepted at cycle 9, not 6.
- Flush with in_valid=1 and no hazard. Required: in_ready=0, next fpu_inst=NOP, fpu_issue=0, existing counters still decrement.
